// File: rtl/bus_rr_pkg.sv
// bus_rr_pkg: shared FSM states, default ID constants and destination-ID extraction
package bus_rr_pkg;
  typedef enum logic [1:0] {IDLE, POP, ROUTE, PUSH} state_e;
  localparam int ID_W = 8;
  localparam logic [7:0] BCST = 8'hFF;
  localparam int MAX_PKT = 1024;
  localparam int MAX_ID = 32;
  // Caller zero-extends the packet to MAX_PKT and truncates the result to its own ID width
  function automatic logic [MAX_ID-1:0] get_id(input logic [MAX_PKT-1:0] pkt, input int w, input int iw);
    return MAX_ID'(pkt >> (w - iw));
  endfunction
endpackage

// File: rtl/bus_rr_router_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after ptr, wrapping
module rr_arbiter import bus_rr_pkg::*; #(
  parameter int n = 8
)(
  input  logic [n-1:0]         req,
  input  logic [$clog2(n)-1:0] ptr,
  output logic [$clog2(n)-1:0] gnt_idx,
  output logic                 gnt_vld
);
  localparam int W = $clog2(n);
  // Second pass overrides the plain lowest-index pick whenever a request sits above ptr
  always_comb begin
    gnt_idx = '0;
    gnt_vld = |req;
    for (int i = n - 1; i >= 0; i--) if (req[i]) gnt_idx = W'(i);
    for (int i = n - 1; i >= 0; i--) if (req[i] && i > int'(ptr)) gnt_idx = W'(i);
  end
endmodule

// File: rtl/bus_rr_router.sv
// bus_rr_router: round-robin pop/route/push between FIFO bus drivers; BUS_RR_SELF_FILTER_EN drops the source from broadcasts
module bus_rr_router import bus_rr_pkg::*; #(
  parameter int pckg_sz = 16,
  parameter int drvs = 8,
  parameter int id_w = ID_W,
  parameter logic [id_w-1:0] bcst = id_w'(BCST)
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [drvs-1:0]                  pndng,
  input  logic [drvs-1:0][pckg_sz-1:0]     D_pop,
  input  logic [drvs-1:0]                  full,
  output logic [drvs-1:0]                  pop,
  output logic [drvs-1:0]                  push,
  output logic [drvs-1:0][pckg_sz-1:0]     D_push,
  output logic                             busy,
  output logic [$clog2(drvs)-1:0]          grant_id,
  output logic                             err_drop
);
  localparam int W = $clog2(drvs);
  state_e state, nxt;
  logic [W-1:0] ptr, gnt_idx;
  logic gnt_vld, valid, blocked;
  logic [pckg_sz-1:0] pkt;
  logic [id_w-1:0] dst;
  logic [drvs-1:0] src, mask;
  rr_arbiter #(.n(drvs)) u_arb (.req(pndng), .ptr(ptr), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld));
  assign src = drvs'(1) << grant_id;
  assign dst = id_w'(get_id(MAX_PKT'(pkt), pckg_sz, id_w));
  assign valid = dst == bcst || 32'(dst) < drvs;
`ifdef BUS_RR_SELF_FILTER_EN
  assign mask = dst == bcst ? ~src : drvs'(1) << dst;
  assign blocked = |(mask & full & ~src);
`else
  assign mask = dst == bcst ? '1 : drvs'(1) << dst;
  assign blocked = |(mask & full);
`endif
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    pop = '0;
    push = '0;
    err_drop = 1'b0;
    case (state)
      IDLE: nxt = gnt_vld ? POP : IDLE;
      POP: begin
        pop = src;
        nxt = ROUTE;
      end
      ROUTE: begin
        err_drop = !valid;
        nxt = !valid ? IDLE : blocked ? ROUTE : PUSH;
      end
      PUSH: begin
        push = mask;
        nxt = gnt_vld ? POP : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= W'(drvs - 1);
      grant_id <= '0;
      pkt <= '0;
      D_push <= '0;
    end else begin
      state <= nxt;
      if ((state == IDLE || state == PUSH) && nxt == POP) grant_id <= gnt_idx;
      if (state == POP) begin
        pkt <= D_pop[grant_id];
        ptr <= grant_id;
      end
      if (state == ROUTE && nxt == PUSH) D_push <= {drvs{pkt}};
    end
endmodule
